cp0: RTL and testbench
======================

# cp0

Coprocessor-0 for the five-stage MIPS pipeline, located in the M stage. It holds the SR, Cause and EPC registers and arbitrates interrupts and exceptions. It raises `req`, which flushes the pipeline, loads the W-stage PC with the handler address 0x0000_4180 and redirects fetch. It also serves `mfc0` reads and `mtc0` writes, and supplies EPC to the next-PC logic for `eret`.

## Interface
- `PRID_VALUE`, default 32'h2024_0601: constant returned by PRId (reg 15) when `CP0_PRID_EN` is defined.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low; clears all CP0 state while low.
- `we`  input  1  `mtc0` write enable from the M stage.
- `addr`  input  5  CP0 register number for reads and writes.
- `din`  input  32  `mtc0` write data (forwarded rt value).
- `vpc`  input  32  PC of the instruction currently in M.
- `bd_in`  input  1  the M instruction sits in a branch delay slot.
- `exc_code_in`  input  5  exception code of the M instruction; 0 = no exception.
- `hw_int`  input  6  external interrupt lines, level-sensitive.
- `eret`  input  1  an `eret` instruction is in M.
- `dout`  output  32  `mfc0` read data, feeding the W-stage register's cp0 input.
- `epc_out`  output  32  current EPC value, used by next-PC for `eret`.
- `req`  output  1  take the exception or interrupt this cycle.

## Operation
- **SR (reg 12):** fields IM[15:10], EXL[1], IE[0]. Only these bits are writable; all other bits read 0.
- **Cause (reg 13):** fields BD[31], IP[15:10], ExcCode[6:2]. It is read-only to `mtc0`; writes to it are ignored.
- **EPC (reg 14):** a write stores {din[31:2], 2'b00}.
- **Interrupt detection:** `int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL`.
- **Exception detection:** `exc_req = (exc_code_in != 0) & ~SR.EXL`.
- **Request output:** `req = int_req | exc_req`, computed combinationally from current state and inputs.
- **On a cycle with `req` = 1** (next edge):
  - SR.EXL ← 1.
  - Cause.BD ← `bd_in`.
  - Cause.ExcCode ← 0 if `int_req`, otherwise `exc_code_in`. Interrupts take priority over exceptions.
  - EPC ← (`bd_in` ? `vpc` − 4 : `vpc`) with bits [1:0] cleared. The subtraction is 32-bit modulo.
- **Priority with `req` = 1:** `we` and `eret` are ignored in that cycle.
- **`eret` with `req` = 0:** SR.EXL ← 0 at the next edge.
- **`eret` and `we` together:** the write applies, and then EXL is cleared. EXL clear wins on SR bit 1.
- **Cause.IP:** ← `hw_int` on every edge, unconditionally, including `req` cycles.
- **`mfc0` reads:** `dout` is combinational from `addr`.
  - Regs 12, 13 and 14 return their current registered values.
  - Reg 15 returns PRId (see Configuration).
  - Any other address returns 0.
  - Reads never bypass a same-cycle write.
- **`epc_out`:** always equals the EPC register.

## Timing
- **Reset (`reset` low):** SR, Cause and EPC go to 0 asynchronously. While reset is asserted, `req` = 0, `dout` = 0 for regs 12–14, and `epc_out` = 0.
- **Reset released mid-sequence:** the block resumes from the all-zero state, with no pending request retained.
- **Latencies:**
  - `req` has 0-cycle latency from its inputs.
  - Register effects of a request, write or `eret` are visible 1 cycle later.
  - `mtc0` followed by `mfc0` in the next cycle reads the new value.
- **Nesting:** while EXL = 1, no further `req` is raised, regardless of `hw_int` or `exc_code_in`.
- **Level-sensitive interrupts:** an interrupt still asserted after `eret` clears EXL raises `req` in the cycle after the `eret` edge.
- **IP vs. `req`:** IP is a 1-cycle-delayed sample of `hw_int`, while `req` uses live `hw_int`.

## Configuration
- **`CP0_PRID_EN` defined:** reg 15 is implemented and reads `PRID_VALUE`; writes to it are ignored.
- **`CP0_PRID_EN` undefined:** reg 15 reads 0, and no PRId logic or parameter use is synthesized.

## Test plan
- **Reset:** assert `reset` = 0 mid-cycle after SR has been written to 0x0000_FC01 -> SR, Cause and EPC read 0 immediately, and `req` = 0.
- **Interrupt:** write SR = 0x0000_0401, then drive `hw_int` = 6'b000001 with `vpc` = 0x0000_3010 and `bd_in` = 0 -> same-cycle `req` = 1; next cycle EPC = 0x0000_3010, ExcCode = 0, EXL = 1, IP[10] = 1.
- **Delay-slot exception:**
  - Stimulus: `exc_code_in` = 12 (Ov), `bd_in` = 1, `vpc` = 0x0000_3024, with a simultaneous `we` to EPC.
  - Response: `req` = 1; EPC = 0x0000_3020, BD = 1, ExcCode = 12; the EPC write is dropped.
- **Nesting and priority:**
  - With EXL = 1, drive `exc_code_in` = 4 plus an enabled `hw_int` -> `req` stays 0.
  - With EXL = 0, drive both -> ExcCode = 0 (interrupt wins).
- **Return:** `eret` with EXL = 1 and enabled `hw_int` held high -> EXL = 0 next cycle, then `req` = 1 in the following cycle.
- **Register access:**
  - `mtc0` SR = 0xFFFF_FFFF -> SR reads 0x0000_FC03.
  - `mtc0` to Cause -> no change.
  - `mfc0` reg 15 -> `PRID_VALUE` when `CP0_PRID_EN` is defined, otherwise 0.
  - `mfc0` reg 7 -> 0.

Source files
------------

// File: rtl/cp0.sv
// cp0: MIPS coprocessor 0 holding SR, Cause and EPC; arbitrates interrupts and exceptions in the M stage.
// Define CP0_PRID_EN to implement the read-only PRId register (reg 15) returning PRID_VALUE.
module cp0
`ifdef CP0_PRID_EN
#(
    parameter logic [31:0] PRID_VALUE = 32'h2024_0601
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic [31:0] dout,
    output logic [31:0] epc_out,
    output logic        req
);

    logic [5:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic [5:0]  ip_r;
    logic [4:0]  exc_code_r;
    logic [31:0] epc_r;

    logic        int_req_s;
    logic        exc_req_s;
    logic        req_s;
    logic [31:0] epc_sel_s;
    logic [31:0] sr_s;
    logic [31:0] cause_s;
    logic [31:0] dout_s;

    // Request arbitration and packed register views
    always_comb begin
        int_req_s = (|(hw_int & im_r)) & ie_r & ~exl_r;
        exc_req_s = (exc_code_in != 5'd0) & ~exl_r;
        req_s     = int_req_s | exc_req_s;
        epc_sel_s = bd_in ? (vpc - 32'd4) : vpc;
        sr_s      = {16'd0, im_r, 8'd0, exl_r, ie_r};
        cause_s   = {bd_r, 15'd0, ip_r, 3'd0, exc_code_r, 2'd0};
    end

    // mfc0 read mux; never bypasses a same-cycle write
    always_comb begin
        dout_s = 32'd0;
        case (addr)
            5'd12:   dout_s = sr_s;
            5'd13:   dout_s = cause_s;
            5'd14:   dout_s = epc_r;
`ifdef CP0_PRID_EN
            5'd15:   dout_s = PRID_VALUE;
`endif
            default: dout_s = 32'd0;
        endcase
    end

    // CP0 state: request capture has priority over mtc0/eret; eret's EXL clear overrides a same-cycle SR write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_r       <= 6'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            ip_r       <= 6'd0;
            exc_code_r <= 5'd0;
            epc_r      <= 32'd0;
        end else begin
            ip_r <= hw_int;
            if (req_s) begin
                exl_r      <= 1'b1;
                bd_r       <= bd_in;
                exc_code_r <= int_req_s ? 5'd0 : exc_code_in;
                epc_r      <= epc_sel_s & 32'hFFFF_FFFC;
            end else begin
                if (we && (addr == 5'd12)) begin
                    im_r  <= din[15:10];
                    exl_r <= din[1];
                    ie_r  <= din[0];
                end
                if (we && (addr == 5'd14)) begin
                    epc_r <= din & 32'hFFFF_FFFC;
                end
                if (eret) begin
                    exl_r <= 1'b0;
                end
            end
        end
    end

    assign dout    = dout_s;
    assign epc_out = epc_r;
    assign req     = req_s;

endmodule

// File: tb/tb_cp0.sv
// Scoreboard testbench for cp0: stimulus pushes expected values, a negedge monitor pops and compares.
module tb_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic [31:0] dout;
    logic [31:0] epc_out;
    logic        req;

`ifdef CP0_PRID_EN
    localparam logic [31:0] PRID_EXP = 32'h2024_0601;
`else
    localparam logic [31:0] PRID_EXP = 32'h0000_0000;
`endif

    localparam int SEL_DOUT = 0;
    localparam int SEL_REQ  = 1;
    localparam int SEL_EPC  = 2;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cp0 dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .addr        (addr),
        .din         (din),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .eret        (eret),
        .dout        (dout),
        .epc_out     (epc_out),
        .req         (req)
    );

    task automatic expect_out(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we          = 1'b0;
        eret        = 1'b0;
        exc_code_in = 5'd0;
        bd_in       = 1'b0;
        din         = 32'd0;
        addr        = 5'd0;
    endtask

    // Monitor: outputs are stable mid-cycle, so drain all pending expectations on the falling edge
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_DOUT: act = dout;
                SEL_REQ:  act = {31'd0, req};
                default:  act = epc_out;
            endcase
            n_tests++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    initial begin
        reset  = 1'b0;
        hw_int = 6'd0;
        vpc    = 32'd0;
        idle();
        #1;
        addr = 5'd12;
        expect_out("reset_sr", SEL_DOUT, 32'h0000_0000);
        expect_out("reset_req", SEL_REQ, 32'd0);
        step();
        step();
        reset = 1'b1;

        // register access
        we = 1'b1; addr = 5'd12; din = 32'hFFFF_FFFF;
        expect_out("req_idle", SEL_REQ, 32'd0);
        step();
        idle(); addr = 5'd12;
        expect_out("sr_mask", SEL_DOUT, 32'h0000_FC03);
        step();
        we = 1'b1; addr = 5'd13; din = 32'hFFFF_FFFF;
        step();
        idle(); addr = 5'd13;
        expect_out("cause_readonly", SEL_DOUT, 32'h0000_0000);
        step();
        addr = 5'd7;
        expect_out("unimpl_reg7", SEL_DOUT, 32'h0000_0000);
        step();
        addr = 5'd15;
        expect_out("prid", SEL_DOUT, PRID_EXP);
        step();

        // mid-sequence reset
        we = 1'b1; addr = 5'd14; din = 32'h1234_5677;
        step();
        idle(); addr = 5'd14;
        expect_out("epc_write", SEL_DOUT, 32'h1234_5674);
        step();
        we = 1'b1; addr = 5'd12; din = 32'h0000_FC01;
        step();
        idle(); addr = 5'd12;
        expect_out("sr_pre_reset", SEL_DOUT, 32'h0000_FC01);
        step();
        reset = 1'b0; hw_int = 6'h3F; addr = 5'd12;
        expect_out("async_reset_sr", SEL_DOUT, 32'h0000_0000);
        expect_out("async_reset_req", SEL_REQ, 32'd0);
        expect_out("async_reset_epc", SEL_EPC, 32'h0000_0000);
        step();
        addr = 5'd13;
        expect_out("reset_cause", SEL_DOUT, 32'h0000_0000);
        hw_int = 6'd0;
        step();
        reset = 1'b1;

        // interrupt
        we = 1'b1; addr = 5'd12; din = 32'h0000_0401;
        step();
        idle(); hw_int = 6'b000001; vpc = 32'h0000_3010; addr = 5'd13;
        expect_out("int_req", SEL_REQ, 32'd1);
        step();
        expect_out("int_exl_masks_req", SEL_REQ, 32'd0);
        expect_out("int_cause", SEL_DOUT, 32'h0000_0400);
        expect_out("int_epc", SEL_EPC, 32'h0000_3010);
        step();
        addr = 5'd12;
        expect_out("int_sr_exl", SEL_DOUT, 32'h0000_0403);
        step();

        // nesting: EXL blocks both exception and interrupt
        exc_code_in = 5'd4;
        expect_out("nest_req", SEL_REQ, 32'd0);
        step();
        exc_code_in = 5'd0; addr = 5'd13;
        expect_out("nest_cause", SEL_DOUT, 32'h0000_0400);
        step();

        // eret with interrupt still high; then interrupt beats exception
        eret = 1'b1;
        expect_out("eret_req", SEL_REQ, 32'd0);
        step();
        eret = 1'b0; addr = 5'd12; exc_code_in = 5'd4; vpc = 32'h0000_3040;
        expect_out("eret_sr", SEL_DOUT, 32'h0000_0401);
        expect_out("eret_reint_req", SEL_REQ, 32'd1);
        step();
        exc_code_in = 5'd0; hw_int = 6'd0; addr = 5'd13;
        expect_out("prio_cause", SEL_DOUT, 32'h0000_0400);
        expect_out("prio_epc", SEL_EPC, 32'h0000_3040);
        step();
        eret = 1'b1;
        step();
        eret = 1'b0;

        // delay-slot exception with a dropped EPC write
        exc_code_in = 5'd12; bd_in = 1'b1; vpc = 32'h0000_3024;
        we = 1'b1; addr = 5'd14; din = 32'hDEAD_BEEF;
        expect_out("ds_req", SEL_REQ, 32'd1);
        step();
        idle(); addr = 5'd13;
        expect_out("ds_cause", SEL_DOUT, 32'h8000_0030);
        expect_out("ds_epc", SEL_EPC, 32'h0000_3020);
        step();
        addr = 5'd14;
        expect_out("ds_epc_read", SEL_DOUT, 32'h0000_3020);
        step();

        // eret and mtc0 SR together: write lands, EXL still cleared
        eret = 1'b1; we = 1'b1; addr = 5'd12; din = 32'h0000_FC03;
        step();
        idle(); addr = 5'd12;
        expect_out("eret_we_sr", SEL_DOUT, 32'h0000_FC01);
        step();

        // delay-slot EPC wraps below zero
        exc_code_in = 5'd10; bd_in = 1'b1; vpc = 32'h0000_0002;
        expect_out("wrap_req", SEL_REQ, 32'd1);
        step();
        idle(); addr = 5'd13;
        expect_out("wrap_cause", SEL_DOUT, 32'h8000_0028);
        expect_out("wrap_epc", SEL_EPC, 32'hFFFF_FFFC);
        step();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
